// File: rtl/mem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: bus command/size encodings,
// address width, and index-width helper.
package mem_arbiter_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned TAG_W = 4;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } mem_command_t;

    typedef enum logic [1:0] {
        MEM_BYTE   = 2'h0,
        MEM_HALF   = 2'h1,
        MEM_WORD   = 2'h2,
        MEM_DOUBLE = 2'h3
    } mem_size_t;

    // Width of an index into n items; never zero so a 1-entry table still has a port.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// rr_picker: picks one eligible channel, searching upward from ptr with wrap.
// Only instantiated when MEM_ARB_RR_EN is defined.
module rr_picker
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]          eligible,
    input  logic [idx_w(NUM_REQ)-1:0]   ptr,
    output logic [NUM_REQ-1:0]          winner
);

    localparam int unsigned IDW = idx_w(NUM_REQ);

    logic           found;
    logic [IDW-1:0] idx;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = IDW'((32'(ptr) + i) % NUM_REQ);
            if (!found && eligible[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: N-channel arbiter onto the single data-memory port with a
// tag-tracked outstanding-load table. MEM_ARB_RR_EN selects round-robin fairness.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned MAX_OUTST = 4,
    parameter int unsigned MEM_W     = 64
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            squash,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ-1:0][1:0]         req_cmd,
    input  logic [NUM_REQ-1:0][XLEN-1:0]    req_addr,
    input  logic [NUM_REQ-1:0][MEM_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0][1:0]         req_size,
    output logic [NUM_REQ-1:0]              gnt,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [MEM_W-1:0]                rsp_data,
    output logic                            table_full,
    output logic [1:0]                      proc2Dmem_command,
    output logic [XLEN-1:0]                 proc2Dmem_addr,
    output logic [MEM_W-1:0]                proc2Dmem_data,
    output logic [1:0]                      proc2Dmem_size,
    input  logic [TAG_W-1:0]                Dmem2proc_response,
    input  logic [MEM_W-1:0]                Dmem2proc_data,
    input  logic [TAG_W-1:0]                Dmem2proc_tag
);

    localparam int unsigned IDW = idx_w(NUM_REQ);
    localparam int unsigned SW  = idx_w(MAX_OUTST);

    typedef struct packed {
        logic             valid;
        logic             killed;
        logic [TAG_W-1:0] tag;
        logic [IDW-1:0]   id;
    } mem_arb_entry_t;

    mem_arb_entry_t         entries_q [MAX_OUTST];
    mem_arb_entry_t         entries_d [MAX_OUTST];
    logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
    logic [MEM_W-1:0]       rsp_data_q, rsp_data_d;
    logic                   full_q, full_d;

    logic [NUM_REQ-1:0]     eligible;
    logic [NUM_REQ-1:0]     winner;
    logic [IDW-1:0]         win_idx;
    logic                   any_win;
    logic                   accept;
    logic                   win_is_load;

    logic                   tag_hit;
    logic [SW-1:0]          hit_idx;
    logic                   free_found;
    logic [SW-1:0]          free_idx;
    int unsigned            valid_cnt;

    // Loads are held off while the table is full; stores bypass the table.
    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req[i] && !squash && !reset &&
                          !((req_cmd[i] == BUS_LOAD) && full_q);
        end
    end

`ifdef MEM_ARB_RR_EN
    logic [IDW-1:0] ptr_q, ptr_d;

    rr_picker #(.NUM_REQ(NUM_REQ)) u_rr_picker (
        .eligible (eligible),
        .ptr      (ptr_q),
        .winner   (winner)
    );

    // Pointer advances only on an accepted grant so a refused channel keeps priority.
    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = (win_idx == IDW'(NUM_REQ - 1)) ? '0 : win_idx + IDW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign winner = eligible & (~eligible + NUM_REQ'(1));
`endif

    always_comb begin
        win_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (winner[i]) begin
                win_idx = IDW'(i);
            end
        end
    end

    assign any_win     = |winner;
    assign accept      = any_win && (Dmem2proc_response != '0);
    assign win_is_load = any_win && (req_cmd[win_idx] == BUS_LOAD);
    assign gnt         = accept ? winner : '0;

    always_comb begin
        proc2Dmem_command = BUS_NONE;
        proc2Dmem_addr    = '0;
        proc2Dmem_data    = '0;
        proc2Dmem_size    = '0;
        if (any_win) begin
            proc2Dmem_command = req_cmd[win_idx];
            proc2Dmem_addr    = req_addr[win_idx];
            proc2Dmem_data    = req_data[win_idx];
            proc2Dmem_size    = req_size[win_idx];
        end
    end

    always_comb begin
        entries_d   = entries_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        tag_hit     = 1'b0;
        hit_idx     = '0;
        free_found  = 1'b0;
        free_idx    = '0;
        valid_cnt   = 0;

        for (int unsigned i = 0; i < MAX_OUTST; i++) begin
            if (!tag_hit && entries_q[i].valid && (Dmem2proc_tag != '0) &&
                (entries_q[i].tag == Dmem2proc_tag)) begin
                tag_hit = 1'b1;
                hit_idx = SW'(i);
            end
            if (!free_found && !entries_q[i].valid) begin
                free_found = 1'b1;
                free_idx   = SW'(i);
            end
        end

        if (tag_hit) begin
            entries_d[hit_idx].valid = 1'b0;
            if (!entries_q[hit_idx].killed && !squash) begin
                rsp_valid_d[entries_q[hit_idx].id] = 1'b1;
                rsp_data_d                         = Dmem2proc_data;
            end
        end

        // Killed entries keep their slot until the memory returns their tag.
        if (squash) begin
            for (int unsigned i = 0; i < MAX_OUTST; i++) begin
                entries_d[i].killed = 1'b1;
            end
        end

        if (accept && win_is_load && free_found) begin
            entries_d[free_idx].valid  = 1'b1;
            entries_d[free_idx].killed = 1'b0;
            entries_d[free_idx].tag    = Dmem2proc_response;
            entries_d[free_idx].id     = win_idx;
        end

        for (int unsigned i = 0; i < MAX_OUTST; i++) begin
            if (entries_d[i].valid) begin
                valid_cnt++;
            end
        end
        full_d = (valid_cnt == MAX_OUTST);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < MAX_OUTST; i++) begin
                entries_q[i] <= '0;
            end
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            full_q      <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < MAX_OUTST; i++) begin
                entries_q[i] <= entries_d[i];
            end
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            full_q      <= full_d;
        end
    end

    // A response already registered when a squash arrives must not reach the FU.
    assign rsp_valid  = rsp_valid_q & {NUM_REQ{~squash}};
    assign rsp_data   = rsp_data_q;
    assign table_full = full_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (NUM_REQ=2, MAX_OUTST=4); expectations follow
// the build mode selected by MEM_ARB_RR_EN.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic                   clock;
    logic                   reset;
    logic                   squash;
    logic [1:0]             req;
    logic [1:0][1:0]        req_cmd;
    logic [1:0][XLEN-1:0]   req_addr;
    logic [1:0][63:0]       req_data;
    logic [1:0][1:0]        req_size;
    logic [1:0]             gnt;
    logic [1:0]             rsp_valid;
    logic [63:0]            rsp_data;
    logic                   table_full;
    logic [1:0]             proc2Dmem_command;
    logic [XLEN-1:0]        proc2Dmem_addr;
    logic [63:0]            proc2Dmem_data;
    logic [1:0]             proc2Dmem_size;
    logic [3:0]             Dmem2proc_response;
    logic [63:0]            Dmem2proc_data;
    logic [3:0]             Dmem2proc_tag;

    int unsigned n_checks;
    int unsigned n_pass;

    mem_arbiter #(.NUM_REQ(2), .MAX_OUTST(4), .MEM_W(64)) dut (
        .clock              (clock),
        .reset              (reset),
        .squash             (squash),
        .req                (req),
        .req_cmd            (req_cmd),
        .req_addr           (req_addr),
        .req_data           (req_data),
        .req_size           (req_size),
        .gnt                (gnt),
        .rsp_valid          (rsp_valid),
        .rsp_data           (rsp_data),
        .table_full         (table_full),
        .proc2Dmem_command  (proc2Dmem_command),
        .proc2Dmem_addr     (proc2Dmem_addr),
        .proc2Dmem_data     (proc2Dmem_data),
        .proc2Dmem_size     (proc2Dmem_size),
        .Dmem2proc_response (Dmem2proc_response),
        .Dmem2proc_data     (Dmem2proc_data),
        .Dmem2proc_tag      (Dmem2proc_tag)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        req                = '0;
        req_cmd            = '0;
        req_addr           = '0;
        req_data           = '0;
        req_size           = '0;
        squash             = 1'b0;
        Dmem2proc_response = '0;
        Dmem2proc_data     = '0;
        Dmem2proc_tag      = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic drive(input int ch, input logic [1:0] cmd, input logic [XLEN-1:0] addr,
                         input logic [63:0] data);
        req[ch]      = 1'b1;
        req_cmd[ch]  = cmd;
        req_addr[ch] = addr;
        req_data[ch] = data;
        req_size[ch] = MEM_WORD;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        idle();
        reset = 1'b1;
        tick();
        tick();
        check("rst_gnt", gnt, 2'b00);
        check("rst_rsp_valid", rsp_valid, 2'b00);
        check("rst_rsp_data", rsp_data, 64'h0);
        check("rst_full", table_full, 1'b0);
        check("rst_cmd", proc2Dmem_command, BUS_NONE);
        reset = 1'b0;

        // Two channels contending: load on ch0, store on ch1.
        do_reset();
        drive(0, BUS_LOAD, 32'h100, 64'h0);
        drive(1, BUS_STORE, 32'h200, 64'h55);
        Dmem2proc_response = 4'd3;
        #1;
        check("prio_gnt_c0", gnt, 2'b01);
        check("prio_addr_c0", proc2Dmem_addr, 32'h100);
        tick();
        check("prio_gnt_c1", gnt, RR ? 2'b10 : 2'b01);
        check("prio_cmd_c1", proc2Dmem_command, RR ? BUS_STORE : BUS_LOAD);
        check("prio_data_c1", proc2Dmem_data, RR ? 64'h55 : 64'h0);

        // Single load round trip.
        do_reset();
        drive(0, BUS_LOAD, 32'h100, 64'h0);
        Dmem2proc_response = 4'd5;
        #1;
        check("ld_gnt", gnt, 2'b01);
        check("ld_cmd", proc2Dmem_command, BUS_LOAD);
        check("ld_size", proc2Dmem_size, MEM_WORD);
        tick();
        idle();
        tick();
        tick();
        tick();
        Dmem2proc_tag  = 4'd5;
        Dmem2proc_data = 64'hDEAD;
        #1;
        check("ld_rsp_pre", rsp_valid, 2'b00);
        tick();
        Dmem2proc_tag = 4'd0;
        check("ld_rsp_valid", rsp_valid, 2'b01);
        check("ld_rsp_data", rsp_data, 64'hDEAD);
        tick();
        check("ld_rsp_pulse", rsp_valid, 2'b00);

        // Fill the table, store bypasses, completion frees a slot.
        do_reset();
        for (int t = 1; t <= 4; t++) begin
            drive(0, BUS_LOAD, 32'h300 + 32'(t), 64'h0);
            Dmem2proc_response = 4'(t);
            #1;
            check("fill_gnt", gnt, 2'b01);
            tick();
            if (t == 3) check("fill_not_full", table_full, 1'b0);
        end
        check("fill_full", table_full, 1'b1);
        drive(1, BUS_STORE, 32'h400, 64'h77);
        Dmem2proc_response = 4'd6;
        #1;
        check("full_store_gnt", gnt, 2'b10);
        tick();
        req[1]             = 1'b0;
        Dmem2proc_response = 4'd7;
        Dmem2proc_tag      = 4'd2;
        Dmem2proc_data     = 64'hBEEF;
        #1;
        check("full_load_held", gnt, 2'b00);
        tick();
        Dmem2proc_tag = 4'd0;
        #1;
        check("free_rsp_valid", rsp_valid, 2'b01);
        check("free_rsp_data", rsp_data, 64'hBEEF);
        check("free_not_full", table_full, 1'b0);
        check("free_load_gnt", gnt, 2'b01);
        tick();
        idle();
        check("refill_full", table_full, 1'b1);

        // Squash kills in-flight loads; they drain without delivering data.
        do_reset();
        drive(0, BUS_LOAD, 32'h500, 64'h0);
        Dmem2proc_response = 4'd6;
        tick();
        Dmem2proc_response = 4'd7;
        tick();
        squash             = 1'b1;
        Dmem2proc_response = 4'd8;
        #1;
        check("sq_no_gnt", gnt, 2'b00);
        check("sq_cmd_none", proc2Dmem_command, BUS_NONE);
        tick();
        idle();
        Dmem2proc_tag  = 4'd6;
        Dmem2proc_data = 64'h66;
        tick();
        check("sq_drop6", rsp_valid, 2'b00);
        Dmem2proc_tag  = 4'd7;
        Dmem2proc_data = 64'h77;
        tick();
        check("sq_drop7", rsp_valid, 2'b00);
        Dmem2proc_tag = 4'd0;
        drive(0, BUS_LOAD, 32'h600, 64'h0);
        Dmem2proc_response = 4'd8;
        #1;
        check("sq_new_gnt", gnt, 2'b01);
        tick();
        Dmem2proc_response = 4'd9;
        tick();
        idle();
        check("sq_table_drained", table_full, 1'b0);
        Dmem2proc_tag  = 4'd8;
        Dmem2proc_data = 64'h88;
        tick();
        check("sq_new_rsp_valid", rsp_valid, 2'b01);
        check("sq_new_rsp_data", rsp_data, 64'h88);
        Dmem2proc_tag  = 4'd9;
        Dmem2proc_data = 64'h99;
        tick();
        Dmem2proc_tag = 4'd0;
        squash        = 1'b1;
        #1;
        check("sq_mask_reg_rsp", rsp_valid, 2'b00);
        tick();
        squash = 1'b0;

        // Refused requests: winner is held and retried.
        do_reset();
        drive(0, BUS_LOAD, 32'h100, 64'h0);
        drive(1, BUS_STORE, 32'h200, 64'h55);
        Dmem2proc_response = 4'd3;
        tick();
        Dmem2proc_response = 4'd0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("refuse_no_gnt", gnt, 2'b00);
            check("refuse_addr", proc2Dmem_addr, RR ? 32'h200 : 32'h100);
            tick();
        end
        Dmem2proc_response = 4'd2;
        #1;
        check("retry_gnt", gnt, RR ? 2'b10 : 2'b01);
        tick();
        Dmem2proc_response = 4'd3;
        #1;
        check("after_retry_gnt", gnt, 2'b01);
        tick();

        // Reset in the middle of an outstanding load.
        do_reset();
        drive(0, BUS_LOAD, 32'h700, 64'h0);
        Dmem2proc_response = 4'd9;
        tick();
        reset = 1'b1;
        #1;
        check("midrst_gnt", gnt, 2'b00);
        check("midrst_cmd", proc2Dmem_command, BUS_NONE);
        check("midrst_rsp_valid", rsp_valid, 2'b00);
        check("midrst_full", table_full, 1'b0);
        tick();
        reset = 1'b0;
        idle();
        Dmem2proc_tag  = 4'd9;
        Dmem2proc_data = 64'h9999;
        tick();
        Dmem2proc_tag = 4'd0;
        check("midrst_stale_tag", rsp_valid, 2'b00);
        check("midrst_rsp_data", rsp_data, 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Parametrised arbiter between the EX-stage memory functional units (loads, stores) and the single data-memory port. Replaces fixed load-over-store priority with N requesters, optional round-robin fairness, and tag-tracked outstanding loads, routing each load response back to its issuing unit. Squash-aware: in-flight loads at a squash are allowed to drain, but their data is never delivered.

## Interface
Parameters:
- NUM_REQ, 2: number of requesting FU channels (≥1)
- MAX_OUTST, 4: maximum outstanding loads (table depth, ≥1)
- MEM_W, 64: memory data width

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- squash  in  1  pipeline squash
- req  in  [NUM_REQ]  channel requests memory this cycle
- req_cmd  in  [NUM_REQ][2]  MEM_COMMAND (BUS_LOAD / BUS_STORE)
- req_addr  in  [NUM_REQ][`XLEN]  byte address
- req_data  in  [NUM_REQ][MEM_W]  store data
- req_size  in  [NUM_REQ][2]  MEM_SIZE
- gnt  out  [NUM_REQ]  one-hot; request accepted by memory this cycle
- rsp_valid  out  [NUM_REQ]  one-hot; load data for that channel
- rsp_data  out  MEM_W  load data (shared)
- table_full  out  1  MAX_OUTST loads outstanding
- proc2Dmem_command  out  2  to memory
- proc2Dmem_addr  out  `XLEN
- proc2Dmem_data  out  MEM_W
- proc2Dmem_size  out  2
- Dmem2proc_response  in  4  nonzero = command accepted, value is its tag
- Dmem2proc_data  in  MEM_W
- Dmem2proc_tag  in  4  nonzero = tag of completing load

## Operation
- Eligible: req[i] && !squash && !(req_cmd[i]==BUS_LOAD && table_full). Stores need no table entry.
- One winner per cycle among eligible channels; the winner's fields drive proc2Dmem_*; no winner → BUS_NONE, other outputs 0.
- Acceptance: Dmem2proc_response != 0 → gnt[winner]=1. For a load, allocate a free entry {valid=1, killed=0, tag=response, id=winner}. Response 0 → no gnt; the requester holds its request and retries.
- Completion: Dmem2proc_tag != 0 matching a valid entry → entry freed; if not killed, rsp_valid[id]=1 and rsp_data=Dmem2proc_data next cycle. An unmatched tag is ignored.
- Squash: every valid entry marked killed (it still occupies its slot until the tag returns); no grant that cycle; a registered rsp_valid presented during the squash cycle is forced to 0.
- Free and allocate in the same cycle both occur; the count changes by net 0. Completion plus squash in the same cycle → entry freed, data dropped.
- table_full = (valid count == MAX_OUTST), registered view.
- Reset: entries invalid, priority pointer 0, rsp_valid 0, rsp_data 0, table_full 0; gnt 0, proc2Dmem_command BUS_NONE.

## Timing
- Request → proc2Dmem_* and gnt: combinational, same cycle.
- Load completion tag → rsp_valid/rsp_data: exactly 1 cycle.
- Table freed by a completion is usable from the next cycle.
- At most one rsp_valid bit set per cycle; rsp_valid is a single-cycle pulse, no ack.

## Configuration
- MEM_ARB_RR_EN defined: round-robin. The pointer moves to winner+1 (mod NUM_REQ) on gnt only; it holds on a refused request, so the refused channel keeps priority.
- Not defined: fixed priority, lowest index wins (channel 0 = load FU); no pointer state.

## Structure
- sys_defs.svh holds MEM_COMMAND and MEM_SIZE (existing) and a new MEM_ARB_ENTRY typedef {valid, killed, tag[4], id[$clog2(NUM_REQ)]}.
- Sub-module rr_picker (NUM_REQ): eligible mask plus pointer → one-hot winner. Used only when MEM_ARB_RR_EN is defined.

## Test plan
- NUM_REQ=2, req=2'b11 (ch0 load, ch1 store), response=3 each cycle → fixed mode: gnt=01 every cycle. RR mode: gnt alternates 01,10.
- Load at addr 0x100 accepted with tag 5; 4 cycles later Dmem2proc_tag=5, data=0xDEAD → next cycle rsp_valid=01, rsp_data=0xDEAD.
- 4 loads accepted with tags 1–4 → table_full=1; a further load on ch0 gets no gnt while a store on ch1 is granted; tag 2 returns → load granted the cycle after.
- Tags 6 and 7 outstanding, squash pulses, then tags 6 and 7 return → no rsp_valid; table empties; a new load is accepted normally afterwards.
- Response=0 for 3 cycles under RR with ch1 winning → ch1 stays winner and is granted on the 4th cycle, when response=2; the pointer then moves to ch0.
- Reset asserted mid-transaction (tag 9 outstanding) → outputs at reset values; a later tag 9 is ignored with no rsp_valid.
